// File: rtl/music_pkg.sv
// ----------------------------------------------------------------------------
// music_pkg
// Shared constants, the sequencer state encoding and a clock-time helper for
// the music sequencer slice.
//   SHEET_NOTE_W / SHEET_DUR_W : default widths of a music-sheet entry
//   REST_MAX                   : note values at or below this are rests
//   CLK_HZ                     : system clock frequency
//   state_t                    : sequencer FSM encoding
//   sec_to_cycles(num, den)    : clock cycles in num/den seconds
// ----------------------------------------------------------------------------
package music_pkg;

  localparam int SHEET_NOTE_W = 20;
  localparam int SHEET_DUR_W  = 5;
  localparam int REST_MAX     = 1;
  localparam int CLK_HZ       = 50_000_000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Fractional seconds as num/den keeps this usable in constant expressions
  // without real arithmetic.
  function automatic int sec_to_cycles(input int num, input int den);
    return int'((longint'(CLK_HZ) * longint'(num)) / longint'(den));
  endfunction

endpackage

// File: rtl/beat_timer.sv
// ----------------------------------------------------------------------------
// beat_timer
// Beat-tick prescaler. Counts 0..TICK_CYCLES-1 while enabled and emits a
// one-cycle tick on the last count. Holds its value while disabled.
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   en     in   advance the prescaler this cycle
//   clr    in   synchronous clear (wins over en)
//   tick   out  high on the cycle the prescaler wraps
//   count  out  cycles elapsed within the current beat
// ----------------------------------------------------------------------------
module beat_timer #(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int CNT_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

  assign tick = en && !clr && (count == LAST);

endmodule

// File: rtl/music_sequencer.sv
// ----------------------------------------------------------------------------
// music_sequencer
// Plays a song from the music-sheet ROM: steps the sheet address, latches each
// entry's note and duration, times it in beat ticks and drives the tone
// generator, leaving a silent articulation gap at the end of every note.
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin (or replay) the song; honoured in IDLE/DONE only
//   stop         in   abort playback, back to IDLE (beats start and pause)
//   pause        in   freeze position and timers, mute the tone
//   sheet_addr   out  entry index into the combinational sheet ROM
//   sheet_note   in   half-period of the addressed entry (<= 1 is a rest)
//   sheet_dur    in   duration of the addressed entry in beat ticks
//   sheet_done   in   addressed entry is the end marker
//   tone_period  out  half-period to the tone generator (registered)
//   tone_en      out  tone generator enable (registered)
//   busy         out  high in FETCH/PLAY/GAP
//   finished     out  one-cycle pulse on entering DONE
//
// state | meaning
// IDLE  | stopped, waiting for start
// FETCH | one cycle: latch the addressed entry and decide what to do with it
// PLAY  | note sounding (or rest), timed against dur*TICK_CYCLES-GAP_CYCLES
// GAP   | articulation silence for the last GAP_CYCLES of the slot
// DONE  | song finished, waiting for start to replay
// ----------------------------------------------------------------------------
module music_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int NOTE_W      = SHEET_NOTE_W,
  parameter int DUR_W       = SHEET_DUR_W,
  parameter int TICK_CYCLES = sec_to_cycles(1, 4),
  parameter int GAP_CYCLES  = sec_to_cycles(1, 100),
  parameter int LOOP        = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  output logic [ADDR_W-1:0] sheet_addr,
  input  logic [NOTE_W-1:0] sheet_note,
  input  logic [DUR_W-1:0]  sheet_dur,
  input  logic              sheet_done,
  output logic [NOTE_W-1:0] tone_period,
  output logic              tone_en,
  output logic              busy,
  output logic              finished
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  // Prescaler value on the final PLAY cycle of the last beat of a note.
  localparam logic [CNT_W-1:0]  PLAY_LAST = CNT_W'(TICK_CYCLES - GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam bit                LOOP_EN   = (LOOP != 0);

  state_t             state, next_state;
  logic [DUR_W-1:0]   dur_q;
  logic [DUR_W-1:0]   beat_q;
  logic [CNT_W-1:0]   pre_cnt;
  logic               tick;
  logic               tmr_en, tmr_clr;
  logic               dur_end, play_end, last_addr;
  logic               advance, load_note;
  logic [ADDR_W-1:0]  addr_d;
  logic [NOTE_W-1:0]  period_d;
  logic               tone_en_d, finished_d;

  beat_timer #(
    .TICK_CYCLES(TICK_CYCLES),
    .CNT_W      (CNT_W)
  ) u_beat_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tmr_en),
    .clr  (tmr_clr),
    .tick (tick),
    .count(pre_cnt)
  );

  // Compare in DUR_W+1 bits so beat+1 cannot overflow for the largest dur.
  assign dur_end   = (({1'b0, beat_q} + (DUR_W+1)'(1)) == {1'b0, dur_q});
  assign play_end  = dur_end && (pre_cnt == PLAY_LAST);
  assign last_addr = (sheet_addr == ADDR_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (sheet_done) begin
          next_state = LOOP_EN ? ST_FETCH : ST_DONE;
        end else if (sheet_dur == '0) begin
          // A skipped entry in the last slot still ends the song; the
          // address never wraps unless looping.
          next_state = (last_addr && !LOOP_EN) ? ST_DONE : ST_FETCH;
        end else begin
          next_state = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (!pause && play_end) next_state = ST_GAP;
      end
      ST_GAP: begin
        // tick is already gated by pause inside the timer enable.
        if (tick && dur_end) begin
          next_state = (last_addr && !LOOP_EN) ? ST_DONE : ST_FETCH;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (stop) next_state = ST_IDLE;
  end

  // --------------------------------------------------------------------------
  // Output / datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    addr_d    = sheet_addr;
    period_d  = tone_period;
    advance   = 1'b0;
    load_note = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) addr_d = '0;
      end
      ST_FETCH: begin
        if (sheet_done) begin
          if (LOOP_EN) addr_d = '0;
        end else if (sheet_dur == '0) begin
          advance = 1'b1;
        end else begin
          load_note = !stop;
        end
      end
      ST_GAP: begin
        if (tick && dur_end) advance = 1'b1;
      end
      default: ;
    endcase

    if (advance) begin
      addr_d = last_addr ? (LOOP_EN ? '0 : sheet_addr) : sheet_addr + 1'b1;
    end
    if (load_note) period_d = sheet_note;

    tmr_en  = ((state == ST_PLAY) || (state == ST_GAP)) && !pause && !stop;
    tmr_clr = stop || !((state == ST_PLAY) || (state == ST_GAP));

    tone_en_d  = (state == ST_PLAY) && !pause && (tone_period > NOTE_W'(REST_MAX));
    finished_d = (next_state == ST_DONE) && (state != ST_DONE);
    busy       = (state == ST_FETCH) || (state == ST_PLAY) || (state == ST_GAP);

    if (stop) begin
      addr_d    = '0;
      period_d  = '0;
      tone_en_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, entry latch and beat counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sheet_addr  <= '0;
      tone_period <= '0;
      tone_en     <= 1'b0;
      finished    <= 1'b0;
      dur_q       <= '0;
      beat_q      <= '0;
    end else begin
      sheet_addr  <= addr_d;
      tone_period <= period_d;
      tone_en     <= tone_en_d;
      finished    <= finished_d;
      if (load_note) dur_q <= sheet_dur;
      if (tmr_clr) begin
        beat_q <= '0;
      end else if (tick) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// ----------------------------------------------------------------------------
// tb_music_sequencer
// Two sequencers on behavioural sheet ROMs (TICK_CYCLES=10, GAP_CYCLES=2):
//   dut_a  LOOP=0, sheet {108932,2},{1,2},{108932,1},done
//   dut_b  LOOP=1, sheet {108932,1},{77000,0},{1,1},done
// A negedge monitor turns each busy address window into a record
// {addr, cycles, tone-high cycles, period seen while high}; tests push the
// expected records when they start the song and compare them afterwards.
// ----------------------------------------------------------------------------
module tb_music_sequencer;

  localparam logic [19:0] NOTE_A = 20'd108932;

  typedef struct packed {
    logic [1:0]  addr;
    logic [7:0]  len;
    logic [7:0]  high;
    logic [19:0] per;
  } rec_t;

  logic        clk;
  logic        rst_n;
  logic        start_a, stop_a, pause_a, start_b, stop_b, pause_b;
  logic [1:0]  addr_a, addr_b;
  logic [19:0] note_a, note_b, per_a, per_b;
  logic [4:0]  dur_a, dur_b;
  logic        done_a, done_b, ten_a, ten_b, busy_a, busy_b, fin_a, fin_b;

  int   checks = 0;
  int   errors = 0;
  rec_t exp_a[$], obs_a[$], exp_b[$], obs_b[$];
  rec_t cur[2];
  bit   open_f[2];
  int   fin_cnt[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  music_sequencer #(.ADDR_W(2), .NOTE_W(20), .DUR_W(5), .TICK_CYCLES(10),
                    .GAP_CYCLES(2), .LOOP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .pause(pause_a),
    .sheet_addr(addr_a), .sheet_note(note_a), .sheet_dur(dur_a), .sheet_done(done_a),
    .tone_period(per_a), .tone_en(ten_a), .busy(busy_a), .finished(fin_a));

  music_sequencer #(.ADDR_W(2), .NOTE_W(20), .DUR_W(5), .TICK_CYCLES(10),
                    .GAP_CYCLES(2), .LOOP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .pause(pause_b),
    .sheet_addr(addr_b), .sheet_note(note_b), .sheet_dur(dur_b), .sheet_done(done_b),
    .tone_period(per_b), .tone_en(ten_b), .busy(busy_b), .finished(fin_b));

  always_comb begin
    note_a = '0; dur_a = '0; done_a = 1'b0;
    case (addr_a)
      2'd0:    begin note_a = NOTE_A; dur_a = 5'd2; end
      2'd1:    begin note_a = 20'd1;  dur_a = 5'd2; end
      2'd2:    begin note_a = NOTE_A; dur_a = 5'd1; end
      default: done_a = 1'b1;
    endcase
  end

  always_comb begin
    note_b = '0; dur_b = '0; done_b = 1'b0;
    case (addr_b)
      2'd0:    begin note_b = NOTE_A;    dur_b = 5'd1; end
      2'd1:    begin note_b = 20'd77000; dur_b = 5'd0; end
      2'd2:    begin note_b = 20'd1;     dur_b = 5'd1; end
      default: done_b = 1'b1;
    endcase
  end

  // Window monitor: one record per contiguous busy stretch at one address.
  always @(negedge clk) begin
    logic        b [2];
    logic [1:0]  ad [2];
    logic        te [2];
    logic [19:0] pr [2];
    logic        fn [2];
    b[0] = busy_a; ad[0] = addr_a; te[0] = ten_a; pr[0] = per_a; fn[0] = fin_a;
    b[1] = busy_b; ad[1] = addr_b; te[1] = ten_b; pr[1] = per_b; fn[1] = fin_b;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        open_f[i] = 1'b0;
      end else begin
        if (fn[i]) fin_cnt[i]++;
        if (open_f[i] && (!b[i] || ad[i] != cur[i].addr)) begin
          if (i == 0) obs_a.push_back(cur[i]);
          else        obs_b.push_back(cur[i]);
          open_f[i] = 1'b0;
        end
        if (b[i] && !open_f[i]) begin
          cur[i]      = '0;
          cur[i].addr = ad[i];
          open_f[i]   = 1'b1;
        end
        if (open_f[i]) begin
          cur[i].len = cur[i].len + 8'd1;
          if (te[i]) begin
            cur[i].high = cur[i].high + 8'd1;
            cur[i].per  = pr[i];
          end
        end
      end
    end
  end

  function automatic rec_t mk(input logic [1:0] a, input int l, input int h,
                              input logic [19:0] p);
    rec_t r;
    r.addr = a; r.len = 8'(l); r.high = 8'(h); r.per = p;
    return r;
  endfunction

  task automatic push_song_a(input int slot0);
    exp_a.push_back(mk(2'd0, slot0, 18, NOTE_A));
    exp_a.push_back(mk(2'd1, 21, 0, 20'd0));
    exp_a.push_back(mk(2'd2, 11, 8, NOTE_A));
    exp_a.push_back(mk(2'd3, 1, 0, 20'd0));
  endtask

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 0; stop_a = 0; pause_a = 0; start_b = 0; stop_b = 0; pause_b = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", addr_a); end
    checks++; if (per_a !== 20'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", per_a); end
    checks++; if (ten_a !== 1'b0) begin errors++; $display("FAIL reset_tone_en got %b exp 0", ten_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (fin_a !== 1'b0) begin errors++; $display("FAIL reset_finished got %b exp 0", fin_a); end
  endtask

  task automatic test_play();
    int f0, n;
    rec_t e, o;
    f0 = fin_cnt[0];
    push_song_a(21);
    pulse_start_a();
    checks++; if (ten_a !== 1'b0) begin errors++; $display("FAIL play_latency_n1 got %b exp 0", ten_a); end
    @(negedge clk);
    checks++; if (ten_a !== 1'b0) begin errors++; $display("FAIL play_latency_n1b got %b exp 0", ten_a); end
    @(negedge clk);
    checks++; if (ten_a !== 1'b1) begin errors++; $display("FAIL play_latency_n2 got %b exp 1", ten_a); end
    n = 0;
    while (fin_cnt[0] == f0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (fin_cnt[0] == f0) begin errors++; $display("FAIL play_finish_timeout got 0 pulses exp 1"); end
    repeat (5) @(negedge clk);
    checks++; if (fin_cnt[0] - f0 != 1) begin errors++; $display("FAIL play_finished_count got %0d exp 1", fin_cnt[0] - f0); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL play_busy_after got %b exp 0", busy_a); end
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL play_rec_count got %0d exp %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL play_rec got addr=%0d len=%0d high=%0d per=%0d exp addr=%0d len=%0d high=%0d per=%0d",
                 o.addr, o.len, o.high, o.per, e.addr, e.len, e.high, e.per);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_pause();
    int f0, n, zeros;
    rec_t e, o;
    f0 = fin_cnt[0];
    push_song_a(28);
    pulse_start_a();
    n = 0;
    while (ten_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    pause_a = 1'b1;
    zeros = 0;
    repeat (7) begin
      @(negedge clk);
      if (ten_a === 1'b0) zeros++;
    end
    pause_a = 1'b0;
    checks++; if (zeros != 7) begin errors++; $display("FAIL pause_low_cycles got %0d exp 7", zeros); end
    checks++; if (per_a !== NOTE_A) begin errors++; $display("FAIL pause_period_held got %0d exp %0d", per_a, NOTE_A); end
    @(negedge clk);
    checks++; if (ten_a !== 1'b1) begin errors++; $display("FAIL pause_resume got %b exp 1", ten_a); end
    n = 0;
    while (fin_cnt[0] == f0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (fin_cnt[0] == f0) begin errors++; $display("FAIL pause_finish_timeout got 0 pulses exp 1"); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL pause_rec_count got %0d exp %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL pause_rec got addr=%0d len=%0d high=%0d per=%0d exp addr=%0d len=%0d high=%0d per=%0d",
                 o.addr, o.len, o.high, o.per, e.addr, e.len, e.high, e.per);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_stop_gap();
    int f0, n;
    rec_t e, o;
    f0 = fin_cnt[0];
    exp_a.push_back(mk(2'd0, 21, 18, NOTE_A));
    exp_a.push_back(mk(2'd1, 21, 0, 20'd0));
    exp_a.push_back(mk(2'd2, 10, 8, NOTE_A));
    pulse_start_a();
    n = 0;
    while (addr_a !== 2'd2 && n < 100) begin @(negedge clk); n++; end
    checks++; if (addr_a !== 2'd2) begin errors++; $display("FAIL stop_reach_entry2 got %0d exp 2", addr_a); end
    repeat (9) @(negedge clk);
    stop_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0; start_a = 1'b0;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stop_busy got %b exp 0", busy_a); end
    checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL stop_addr got %0d exp 0", addr_a); end
    checks++; if (ten_a !== 1'b0) begin errors++; $display("FAIL stop_tone_en got %b exp 0", ten_a); end
    checks++; if (per_a !== 20'd0) begin errors++; $display("FAIL stop_period got %0d exp 0", per_a); end
    repeat (30) @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stop_stays_idle got %b exp 0", busy_a); end
    checks++; if (fin_cnt[0] != f0) begin errors++; $display("FAIL stop_no_finished got %0d exp 0", fin_cnt[0] - f0); end
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL stop_rec_count got %0d exp %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stop_rec got addr=%0d len=%0d high=%0d per=%0d exp addr=%0d len=%0d high=%0d per=%0d",
                 o.addr, o.len, o.high, o.per, e.addr, e.len, e.high, e.per);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_reset_mid_play();
    int f0, n;
    rec_t e, o;
    pulse_start_a();
    n = 0;
    while (ten_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ten_a !== 1'b0) begin errors++; $display("FAIL rstmid_tone_en got %b exp 0", ten_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_a); end
    checks++; if (addr_a !== 2'd0) begin errors++; $display("FAIL rstmid_addr got %0d exp 0", addr_a); end
    checks++; if (per_a !== 20'd0) begin errors++; $display("FAIL rstmid_period got %0d exp 0", per_a); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    obs_a.delete();
    f0 = fin_cnt[0];
    push_song_a(21);
    pulse_start_a();
    n = 0;
    while (fin_cnt[0] == f0 && n < 300) begin @(negedge clk); n++; end
    checks++; if (fin_cnt[0] == f0) begin errors++; $display("FAIL rstmid_finish_timeout got 0 pulses exp 1"); end
    repeat (5) @(negedge clk);
    checks++;
    if (obs_a.size() != exp_a.size()) begin errors++; $display("FAIL rstmid_rec_count got %0d exp %0d", obs_a.size(), exp_a.size()); end
    while (exp_a.size() > 0 && obs_a.size() > 0) begin
      e = exp_a.pop_front(); o = obs_a.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rstmid_rec got addr=%0d len=%0d high=%0d per=%0d exp addr=%0d len=%0d high=%0d per=%0d",
                 o.addr, o.len, o.high, o.per, e.addr, e.len, e.high, e.per);
      end
    end
    exp_a.delete(); obs_a.delete();
  endtask

  task automatic test_loop_skip();
    int f1, n;
    rec_t e, o;
    f1 = fin_cnt[1];
    for (int k = 0; k < 2; k++) begin
      exp_b.push_back(mk(2'd0, 11, 8, NOTE_A));
      exp_b.push_back(mk(2'd1, 1, 0, 20'd0));
      exp_b.push_back(mk(2'd2, 11, 0, 20'd0));
      exp_b.push_back(mk(2'd3, 1, 0, 20'd0));
    end
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (obs_b.size() < 8 && n < 200) begin @(negedge clk); n++; end
    checks++; if (obs_b.size() < 8) begin errors++; $display("FAIL loop_rec_count got %0d exp 8", obs_b.size()); end
    checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL loop_still_busy got %b exp 1", busy_b); end
    @(negedge clk) stop_b = 1'b1;
    @(negedge clk) stop_b = 1'b0;
    checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL loop_stop_busy got %b exp 0", busy_b); end
    checks++; if (addr_b !== 2'd0) begin errors++; $display("FAIL loop_stop_addr got %0d exp 0", addr_b); end
    checks++; if (fin_cnt[1] != f1) begin errors++; $display("FAIL loop_no_finished got %0d exp 0", fin_cnt[1] - f1); end
    while (exp_b.size() > 0 && obs_b.size() > 0) begin
      e = exp_b.pop_front(); o = obs_b.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL loop_rec got addr=%0d len=%0d high=%0d per=%0d exp addr=%0d len=%0d high=%0d per=%0d",
                 o.addr, o.len, o.high, o.per, e.addr, e.len, e.high, e.per);
      end
    end
    exp_b.delete(); obs_b.delete();
  endtask

  initial begin
    fin_cnt[0] = 0; fin_cnt[1] = 0;
    open_f[0] = 1'b0; open_f[1] = 1'b0;
    test_reset();
    test_play();
    test_pause();
    test_stop_gap();
    test_reset_mid_play();
    test_loop_skip();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
